// File: rtl/riscv_defines.sv
// riscv_defines
//   Shared types and defaults for the PratеRV data-bus router.
//   dbus_state_e          : router FSM state encoding
//   PERIPH_REGION_DEFAULT : addr[31:28] value selecting peripheral space
//   TIMEOUT_CNT_W         : width of the wait-cycle counter
package riscv_defines;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2,
    ERR_RESP    = 2'd3
  } dbus_state_e;

  localparam logic [3:0]  PERIPH_REGION_DEFAULT = 4'h1;
  localparam int unsigned TIMEOUT_CNT_W         = 8;

endpackage

// File: rtl/riscv_praterv_addr_decode.sv
// riscv_praterv_addr_decode
//   Purely combinational target decode for the data-bus router.
//   addr      in  32             request address (only [31:24] matter)
//   periph_en in  PERIPHERAL_NO  per-peripheral enable mask
//   tgt_idx   out 4              0 = memory, k+1 = peripheral k
//   dec_err   out 1              peripheral index out of range or disabled
module riscv_praterv_addr_decode
  import riscv_defines::*;
#(
  parameter int unsigned PERIPHERAL_NO = 2,
  parameter logic [3:0]  PERIPH_REGION = PERIPH_REGION_DEFAULT
) (
  input  logic [31:0]              addr,
  input  logic [PERIPHERAL_NO-1:0] periph_en,
  output logic [3:0]               tgt_idx,
  output logic                     dec_err
);

  logic [3:0] idx;
  logic       en_hit;
  logic       unused_addr_lo;

  assign unused_addr_lo = ^addr[23:0];

  always_comb begin
    idx     = addr[27:24];
    en_hit  = 1'b0;
    tgt_idx = 4'd0;
    dec_err = 1'b0;
    // An index beyond PERIPHERAL_NO never matches, so en_hit stays 0 and
    // both error causes collapse into a single check.
    for (int k = 0; k < PERIPHERAL_NO; k++) begin
      if (idx == 4'(k)) en_hit = periph_en[k];
    end
    if (addr[31:28] == PERIPH_REGION) begin
      if (en_hit) tgt_idx = idx + 4'd1;
      else        dec_err = 1'b1;
    end
  end

endmodule

// File: rtl/riscv_praterv_dbus_router.sv
// riscv_praterv_dbus_router
//   Routes single outstanding data-side requests to memory (target 0) or
//   one of PERIPHERAL_NO peripherals, with decode-error and timeout responses.
//   clk, rst                 clock, synchronous active-high reset
//   req_i/addr_i/we_i/be_i/wdata_i   upstream request
//   gnt_o                    combinational accept (IDLE only)
//   rvalid_o/rdata_o/err_o   registered one-cycle response
//   periph_en_i              peripheral enable mask, sampled at acceptance
//   tgt_req_o/tgt_gnt_i/tgt_rvalid_i/tgt_rdata_i   per-target handshake
//   bus_addr_o/bus_we_o/bus_be_o/bus_wdata_o       registered shared bus
//
//   state       | meaning
//   IDLE        | no transaction; gnt_o follows req_i
//   WAIT_GNT    | tgt_req_o asserted on selected target until its grant
//   WAIT_RVALID | request dropped, waiting for the target response
//   ERR_RESP    | one-cycle gap while the error response is on rvalid_o
module riscv_praterv_dbus_router
  import riscv_defines::*;
#(
  parameter int unsigned PERIPHERAL_NO  = 2,
  parameter logic [3:0]  PERIPH_REGION  = PERIPH_REGION_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_i,
  input  logic [31:0]                   addr_i,
  input  logic                          we_i,
  input  logic [3:0]                    be_i,
  input  logic [31:0]                   wdata_i,
  output logic                          gnt_o,
  output logic                          rvalid_o,
  output logic [31:0]                   rdata_o,
  output logic                          err_o,
  input  logic [PERIPHERAL_NO-1:0]      periph_en_i,
  output logic [PERIPHERAL_NO:0]        tgt_req_o,
  input  logic [PERIPHERAL_NO:0]        tgt_gnt_i,
  input  logic [PERIPHERAL_NO:0]        tgt_rvalid_i,
  input  logic [PERIPHERAL_NO:0][31:0]  tgt_rdata_i,
  output logic [31:0]                   bus_addr_o,
  output logic                          bus_we_o,
  output logic [3:0]                    bus_be_o,
  output logic [31:0]                   bus_wdata_o
);

  localparam int unsigned NT = PERIPHERAL_NO + 1;
  // Counter value on the last permitted wait cycle; TIMEOUT_CYCLES must be 1..255.
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

  dbus_state_e              state_q;
  logic [NT-1:0]            tgt_oh_q;
  logic [TIMEOUT_CNT_W-1:0] cnt_q;

  logic [3:0]    dec_idx;
  logic          dec_err;
  logic [NT-1:0] dec_oh;
  logic          sel_gnt;
  logic          sel_rvalid;
  logic [31:0]   sel_rdata;
  logic          timeout_hit;

  riscv_praterv_addr_decode #(
    .PERIPHERAL_NO (PERIPHERAL_NO),
    .PERIPH_REGION (PERIPH_REGION)
  ) u_addr_decode (
    .addr      (addr_i),
    .periph_en (periph_en_i),
    .tgt_idx   (dec_idx),
    .dec_err   (dec_err)
  );

  always_comb begin
    dec_oh = '0;
    for (int k = 0; k < NT; k++) dec_oh[k] = (dec_idx == 4'(k));
  end

  // Masking with the registered one-hot ignores every non-selected target.
  assign sel_gnt    = |(tgt_gnt_i & tgt_oh_q);
  assign sel_rvalid = |(tgt_rvalid_i & tgt_oh_q);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NT; k++) begin
      if (tgt_oh_q[k]) sel_rdata = sel_rdata | tgt_rdata_i[k];
    end
  end

  assign timeout_hit = (cnt_q == TIMEOUT_LAST);
  assign gnt_o       = req_i && (state_q == IDLE);
  assign tgt_req_o   = (state_q == WAIT_GNT) ? tgt_oh_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tgt_oh_q    <= '0;
      cnt_q       <= '0;
      rvalid_o    <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      bus_addr_o  <= '0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
    end else begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            if (dec_err) begin
              // Error response is launched on entry so it appears the cycle
              // after the request, while ERR_RESP blocks a new accept.
              state_q  <= ERR_RESP;
              rvalid_o <= 1'b1;
              err_o    <= 1'b1;
            end else begin
              state_q     <= WAIT_GNT;
              tgt_oh_q    <= dec_oh;
              cnt_q       <= '0;
              bus_addr_o  <= addr_i;
              bus_we_o    <= we_i;
              bus_be_o    <= be_i;
              bus_wdata_o <= wdata_i;
            end
          end
        end
        WAIT_GNT: begin
          cnt_q <= cnt_q + 1'b1;
          if (sel_gnt) begin
            state_q <= WAIT_RVALID;
          end else if (timeout_hit) begin
            state_q  <= ERR_RESP;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
          end
        end
        WAIT_RVALID: begin
          cnt_q <= cnt_q + 1'b1;
          if (sel_rvalid) begin
            state_q  <= IDLE;
            rvalid_o <= 1'b1;
            rdata_o  <= sel_rdata;
          end else if (timeout_hit) begin
            state_q  <= ERR_RESP;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
          end
        end
        ERR_RESP: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule
